// File: rtl/addsub_sat.sv
// addsub_sat: registered 16-bit signed add/subtract with two's-complement
// saturation and an overflow flag. The result appears one cycle after capture.
// The 16-bit adder is four 4-bit carry-lookahead groups chained by group carry.
// Optional build macro ADDSUB_FLAGS_EN adds registered zero/neg flags taken
// from the saturated result.

// 4-bit carry-lookahead group: the carries come from generate/propagate terms
// expanded in full, so no ripple path runs inside the group.
module addsub_sat_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  // generate/propagate and fully expanded lookahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module addsub_sat (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        ovfl,
  output logic        out_valid
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic        zero,
  output logic        neg
`endif
);
  localparam int NUM_GRP = 4;

  logic [15:0] bx, raw, sat;
  logic [NUM_GRP:0] gc;
  logic        pos_ovf, neg_ovf;
  logic        carry_unused;

  logic [15:0] sum_d, sum_q;
  logic        ovfl_d, ovfl_q;
  logic        out_valid_d, out_valid_q;

  // subtraction is a + ~b + 1; the +1 enters as the carry-in of group 0
  assign bx    = sub ? ~b : b;
  assign gc[0] = sub;

  for (genvar i = 0; i < NUM_GRP; i++) begin : g_grp
    addsub_sat_cla4 u_cla (
      .a    (a[4*i +: 4]),
      .b    (bx[4*i +: 4]),
      .cin  (gc[i]),
      .s    (raw[4*i +: 4]),
      .cout (gc[i+1])
    );
  end

  // carry-out of bit 15 plays no part in signed overflow
  assign carry_unused = gc[NUM_GRP];

  // overflow detection, clamp selection and hold-when-idle next state
  always_comb begin
    pos_ovf     = ~a[15] & ~bx[15] &  raw[15];
    neg_ovf     =  a[15] &  bx[15] & ~raw[15];
    sat         = pos_ovf ? 16'h7FFF : (neg_ovf ? 16'h8000 : raw);
    out_valid_d = in_valid;
    sum_d       = sum_q;
    ovfl_d      = ovfl_q;
    if (in_valid) begin
      sum_d  = sat;
      ovfl_d = pos_ovf | neg_ovf;
    end
  end

  // result registers; reset clears immediately, without waiting for a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= 16'h0000;
      ovfl_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      ovfl_q      <= ovfl_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign ovfl      = ovfl_q;
  assign out_valid = out_valid_q;

`ifdef ADDSUB_FLAGS_EN
  logic zero_d, zero_q, neg_d, neg_q;

  // flags follow the saturated value with the same enable as sum
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (in_valid) begin
      zero_d = (sat == 16'h0000);
      neg_d  = sat[15];
    end
  end

  // flag registers; the reset value matches a zero sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
`endif
endmodule

// File: tb/tb_addsub_sat.sv
// Testbench for addsub_sat. Expected results are queued when an operation is
// driven and popped when out_valid shows a result.
module tb_addsub_sat;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [15:0] sum;
  logic        ovfl, out_valid;
`ifdef ADDSUB_FLAGS_EN
  logic        zero, neg;
`endif

  typedef struct packed {
    logic [15:0] s;
    logic        o;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_sum = '0;
  logic        last_ovfl = 1'b0;

  addsub_sat dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sum       (sum),
    .ovfl      (ovfl),
    .out_valid (out_valid)
`ifdef ADDSUB_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg)
`endif
  );

  always #5 clk = ~clk;

  // saturating signed reference computed with wide integer arithmetic
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    int   xi, yi, r;
    exp_t e;
    xi = int'($signed(x));
    yi = int'($signed(y));
    r  = s ? (xi - yi) : (xi + yi);
    if (r > 32767) begin
      e.s = 16'h7FFF; e.o = 1'b1;
    end else if (r < -32768) begin
      e.s = 16'h8000; e.o = 1'b1;
    end else begin
      e.s = r[15:0];  e.o = 1'b0;
    end
    return e;
  endfunction

  // present one operation on the next falling edge and queue its expectation
  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic s,
                       input logic [15:0] es, input logic eo);
    exp_t e;
    @(negedge clk);
    a = x; b = y; sub = s; in_valid = 1'b1;
    e.s = es; e.o = eo;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    #1 rst_n = 1'b0;
    a = 16'h1234; b = 16'h5678; sub = 1'b1; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sum, ovfl, out_valid} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got sum=%h ovfl=%b vld=%b want 0000/0/0", sum, ovfl, out_valid);
    end
`ifdef ADDSUB_FLAGS_EN
    checks++;
    if ({zero, neg} !== 2'b10) begin
      errors++;
      $display("FAIL reset_flags got zero=%b neg=%b want 1/0", zero, neg);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    drive(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || sbq.size() == 0) begin
      errors++; sbq.delete();
      $display("FAIL reset_first_vld got vld=%b want 1", out_valid);
    end else begin
      e = sbq.pop_front();
      checks++;
      if ({sum, ovfl} !== {e.s, e.o}) begin
        errors++;
        $display("FAIL reset_first got sum=%h ovfl=%b want %h/%b", sum, ovfl, e.s, e.o);
      end
      last_sum = e.s; last_ovfl = e.o;
    end
  endtask

  // directed table: add/sub, both saturation directions and the 8000 edges
  task automatic test_directed();
    logic [15:0] va[9], vb[9], vs[9];
    logic        vsub[9], vo[9];
    exp_t        e;
    va = '{16'h0020, 16'h0001, 16'h7FFF, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF};
    vb = '{16'h0010, 16'h0002, 16'h0001, 16'h8000, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000, 16'hFFFF};
    vsub = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vs = '{16'h0010, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF};
    vo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive(va[i], vb[i], vsub[i], vs[i], vo[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sbq.size() == 0) begin
        errors++; sbq.delete();
        $display("FAIL directed_vld[%0d] got vld=%b want 1", i, out_valid);
      end else begin
        e = sbq.pop_front();
        checks++;
        if ({sum, ovfl} !== {e.s, e.o}) begin
          errors++;
          $display("FAIL directed[%0d] %h %s %h got sum=%h ovfl=%b want %h/%b",
                   i, va[i], vsub[i] ? "-" : "+", vb[i], sum, ovfl, e.s, e.o);
        end
`ifdef ADDSUB_FLAGS_EN
        checks++;
        if ({zero, neg} !== {(e.s == 16'h0000), e.s[15]}) begin
          errors++;
          $display("FAIL directed_flags[%0d] got zero=%b neg=%b want %b/%b",
                   i, zero, neg, (e.s == 16'h0000), e.s[15]);
        end
`endif
        last_sum = e.s; last_ovfl = e.o;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va[4], vb[4], vs[4];
    logic        vsub[4], vo[4];
    exp_t        e;
    va = '{16'h0100, 16'h0200, 16'h7000, 16'h9000};
    vb = '{16'h0001, 16'h0003, 16'h2000, 16'h2000};
    vsub = '{1'b0, 1'b1, 1'b0, 1'b1};
    vs = '{16'h0101, 16'h01FD, 16'h7FFF, 16'h8000};
    vo = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], vsub[i], vs[i], vo[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sbq.size() == 0) begin
        errors++; sbq.delete();
        $display("FAIL b2b_vld[%0d] got vld=%b want 1", i, out_valid);
      end else begin
        e = sbq.pop_front();
        checks++;
        if ({sum, ovfl} !== {e.s, e.o}) begin
          errors++;
          $display("FAIL b2b[%0d] got sum=%h ovfl=%b want %h/%b", i, sum, ovfl, e.s, e.o);
        end
        last_sum = e.s; last_ovfl = e.o;
      end
    end
  endtask

  // idle cycles: out_valid drops while the last result stays visible
  task automatic test_hold();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a = 16'h7FFF; b = 16'h7FFF; sub = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, sum, ovfl} !== {1'b0, last_sum, last_ovfl}) begin
        errors++;
        $display("FAIL hold[%0d] got vld=%b sum=%h ovfl=%b want 0/%h/%b",
                 i, out_valid, sum, ovfl, last_sum, last_ovfl);
      end
`ifdef ADDSUB_FLAGS_EN
      checks++;
      if ({zero, neg} !== {(last_sum == 16'h0000), last_sum[15]}) begin
        errors++;
        $display("FAIL hold_flags[%0d] got zero=%b neg=%b", i, zero, neg);
      end
`endif
    end
  endtask

  // reset between edges clears outputs at once and discards the pending op
  task automatic test_async_reset();
    exp_t e;
    drive(16'h0123, 16'h0001, 1'b0, 16'h0124, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || sbq.size() == 0) begin
      errors++; sbq.delete();
      $display("FAIL arst_pre_vld got vld=%b want 1", out_valid);
    end else begin
      e = sbq.pop_front();
      checks++;
      if (sum !== e.s) begin
        errors++;
        $display("FAIL arst_pre got sum=%h want %h", sum, e.s);
      end
    end
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum, ovfl, out_valid} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arst_immediate got sum=%h ovfl=%b vld=%b want 0000/0/0", sum, ovfl, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({sum, ovfl, out_valid} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arst_held got sum=%h ovfl=%b vld=%b want 0000/0/0", sum, ovfl, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    drive(16'hFFFE, 16'h0003, 1'b1, 16'hFFFB, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || sbq.size() == 0) begin
      errors++; sbq.delete();
      $display("FAIL arst_after_vld got vld=%b want 1", out_valid);
    end else begin
      e = sbq.pop_front();
      checks++;
      if ({sum, ovfl} !== {e.s, e.o}) begin
        errors++;
        $display("FAIL arst_after got sum=%h ovfl=%b want %h/%b", sum, ovfl, e.s, e.o);
      end
      last_sum = e.s; last_ovfl = e.o;
    end
  endtask

  task automatic test_random();
    logic [15:0] corner[4], x, y;
    logic        s;
    exp_t        m, e;
    corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int i = 0; i < 10000; i++) begin
      x = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 16'($urandom);
      y = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 16'($urandom);
      s = 1'($urandom);
      m = model(x, y, s);
      drive(x, y, s, m.s, m.o);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sbq.size() == 0) begin
        errors++; sbq.delete();
        $display("FAIL rand_vld[%0d] got vld=%b want 1", i, out_valid);
      end else begin
        e = sbq.pop_front();
        if ({sum, ovfl} !== {e.s, e.o}) begin
          errors++;
          $display("FAIL rand[%0d] %h %s %h got sum=%h ovfl=%b want %h/%b",
                   i, x, s ? "-" : "+", y, sum, ovfl, e.s, e.o);
        end
`ifdef ADDSUB_FLAGS_EN
        if ({zero, neg} !== {(e.s == 16'h0000), e.s[15]}) begin
          errors++;
          $display("FAIL rand_flags[%0d] got zero=%b neg=%b", i, zero, neg);
        end
`endif
        last_sum = e.s; last_ovfl = e.o;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
